// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA channel I/O port.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  localparam logic DIR_DEV2MEM = 1'b0;
  localparam logic DIR_MEM2DEV = 1'b1;

  localparam int DMA_DW_DEFAULT = 8;

endpackage

// File: rtl/dma_sync_fifo.sv
// First-word fall-through FIFO; pop and push in the same cycle keep the count.
module dma_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [DW-1:0]              din_i,
  output logic [DW-1:0]              head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_pulse_o,
  output logic                       unf_pulse_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);

  // A pop frees the slot, so a push into a full FIFO is accepted when paired with one.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign ovf_pulse_o = push_i & full_o & ~do_pop;
  assign unf_pulse_o = pop_i & empty_o;

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dma_io_port.sv
// Device-side DMA channel port: buffers peripheral data and handshakes with the DMAC I/O side.
module dma_io_port
  import dma_pkg::*;
#(
  parameter int DW     = DMA_DW_DEFAULT,
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DIR,
  input  logic          CLR,
  input  logic          DEV_WR,
  input  logic [DW-1:0] DEV_DATA,
  input  logic          DEV_RD,
  output logic [DW-1:0] DEV_Q,
  output logic          DEV_FULL,
  output logic          DEV_EMPTY,
  output logic          DREQ,
  input  logic          DACK,
  input  logic          IOR,
  input  logic          IOW,
  input  logic          EOP,
  output logic [DW-1:0] BUS_DOUT,
  input  logic [DW-1:0] BUS_DIN,
  output logic          RDY,
  output logic          DONE,
  output logic          OVF,
  output logic          UNF
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  dma_state_e    state_q;
  logic          dir_q;
  logic          dreq_q, done_q, ovf_q, unf_q;

  logic          bus_pop, bus_push;
  logic          fifo_push, fifo_pop;
  logic [DW-1:0] fifo_din, fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          ovf_pulse, unf_pulse;
  logic          thresh_met, release_req, eop_hit;

  assign bus_pop  = DACK & IOR & (dir_q == DIR_DEV2MEM);
  assign bus_push = DACK & IOW & (dir_q == DIR_MEM2DEV);

  assign fifo_push = (dir_q == DIR_MEM2DEV) ? bus_push : DEV_WR;
  assign fifo_pop  = (dir_q == DIR_MEM2DEV) ? DEV_RD   : bus_pop;
  assign fifo_din  = (dir_q == DIR_MEM2DEV) ? BUS_DIN  : DEV_DATA;

  dma_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .flush_i     (CLR),
    .din_i       (fifo_din),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .ovf_pulse_o (ovf_pulse),
    .unf_pulse_o (unf_pulse)
  );

  // Thresholds look at the registered count, i.e. the count after the previous edge's update.
  assign thresh_met  = (dir_q == DIR_DEV2MEM) ? (fifo_count >= THRESH_C)
                                              : ((DEPTH_C - fifo_count) >= THRESH_C);
  assign release_req = (dir_q == DIR_DEV2MEM) ? fifo_empty : fifo_full;
  assign eop_hit     = DACK & EOP;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_DEV2MEM;
      dreq_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) dir_q <= DIR;
      if (ovf_pulse) ovf_q <= 1'b1;
      // A device-side pop on empty is harmless; only a DMAC read on empty is an underflow.
      if (unf_pulse && dir_q == DIR_DEV2MEM) unf_q <= 1'b1;

      if (CLR) begin
        state_q <= ST_IDLE;
        dreq_q  <= 1'b0;
        done_q  <= 1'b0;
        ovf_q   <= 1'b0;
        unf_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ARMED;
            dreq_q  <= 1'b0;
          end
          ST_ARMED: begin
            if (eop_hit) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dreq_q  <= 1'b0;
            end else if (thresh_met) begin
              state_q <= ST_REQ;
              dreq_q  <= 1'b1;
            end
          end
          ST_REQ: begin
            if (eop_hit) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dreq_q  <= 1'b0;
            end else if (release_req) begin
              state_q <= ST_ARMED;
              dreq_q  <= 1'b0;
            end
          end
          ST_DONE: begin
            dreq_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            dreq_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign RDY       = DACK & (((dir_q == DIR_DEV2MEM) & ~fifo_empty) |
                             ((dir_q == DIR_MEM2DEV) & ~fifo_full));
  assign BUS_DOUT  = fifo_head;
  assign DEV_Q     = fifo_head;
  assign DEV_FULL  = fifo_full;
  assign DEV_EMPTY = fifo_empty;
  assign DREQ      = dreq_q;
  assign DONE      = done_q;
  assign OVF       = ovf_q;
  assign UNF       = unf_q;

endmodule
